// File: rtl/wb_queue.sv
// wb_queue: two-producer write-back FIFO feeding one register-file write port,
// with pending-write lookup for decode operand addresses.
module wb_queue #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       a_valid,
   input  logic [4:0]                 a_addr,
   input  logic [31:0]                a_data,
   output logic                       a_ready,
   input  logic                       b_valid,
   input  logic [4:0]                 b_addr,
   input  logic [31:0]                b_data,
   output logic                       b_ready,
   output logic                       we,
   output logic [4:0]                 waddr,
   output logic [31:0]                wdata,
   input  logic [4:0]                 chk_addr1,
   input  logic [4:0]                 chk_addr2,
   output logic                       chk_busy1,
   output logic                       chk_busy2,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   logic [4:0]    addr_q [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [AW-1:0] head, tail, off;
   logic          not_full, a_hs, b_hs, enq, occ;
   logic [4:0]    in_addr;
   logic [31:0]   in_data;
   assign not_full = count < (AW+1)'(DEPTH);
   assign a_ready  = not_full;
   assign b_ready  = not_full && !a_valid;
   assign a_hs     = a_valid && a_ready;
   assign b_hs     = b_valid && b_ready;
   assign in_addr  = a_hs ? a_addr : b_addr;
   assign in_data  = a_hs ? a_data : b_data;
   // writes to r0 complete the handshake but are dropped
   assign enq      = !rst && (a_hs || b_hs) && in_addr != 5'd0;
   // the reset edge must not commit a write of an entry that is being flushed
   assign we       = count != '0 && !rst;
   assign waddr    = we ? addr_q[head] : 5'd0;
   assign wdata    = we ? data_q[head] : 32'd0;
   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + AW'(we);
         tail  <= tail + AW'(enq);
         count <= count + (AW+1)'(enq) - (AW+1)'(we);
      end
   end
   always_ff @(posedge clk) begin
      if (enq) begin
         addr_q[tail] <= in_addr;
         data_q[tail] <= in_data;
      end
   end
   // an entry is occupied when its distance from head is below count
   always_comb begin
      chk_busy1 = 1'b0;
      chk_busy2 = 1'b0;
      off       = '0;
      occ       = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         off       = AW'(i) - head;
         occ       = {1'b0, off} < count;
         chk_busy1 = chk_busy1 | (occ && chk_addr1 != 5'd0 && addr_q[i] == chk_addr1);
         chk_busy2 = chk_busy2 | (occ && chk_addr2 != 5'd0 && addr_q[i] == chk_addr2);
      end
   end
endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: directed stimulus with a scoreboard of expected register-file
// writes; a negedge monitor pops and compares every retirement.
module tb_wb_queue;
   localparam int DEPTH = 4;
   logic        clk = 1'b0;
   logic        rst, a_valid, b_valid, a_ready, b_ready, we, chk_busy1, chk_busy2;
   logic [4:0]  a_addr, b_addr, waddr, chk_addr1, chk_addr2;
   logic [31:0] a_data, b_data, wdata;
   logic [2:0]  count;
   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;
   ent_t sbq[$];
   int   vecs = 0;
   int   miss = 0;
   int   mcount = 0;

   wb_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
      .we(we), .waddr(waddr), .wdata(wdata),
      .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
      .chk_busy1(chk_busy1), .chk_busy2(chk_busy2), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // acceptance model: pushes expected writes when a handshake completes
   always @(posedge clk) begin : model
      logic ahs, bhs;
      int   dq;
      ahs = !rst && a_valid && mcount < DEPTH;
      bhs = !rst && b_valid && !a_valid && mcount < DEPTH;
      dq  = (!rst && mcount != 0) ? 1 : 0;
      if (rst) mcount = 0;
      else begin
         if (ahs && a_addr != 5'd0) begin
            sbq.push_back({a_addr, a_data});
            mcount++;
         end else if (bhs && b_addr != 5'd0) begin
            sbq.push_back({b_addr, b_data});
            mcount++;
         end
         mcount -= dq;
      end
   end

   always @(negedge clk) begin : monitor
      ent_t e;
      if (rst) begin
         chk("we_during_rst", 32'(we), 32'd0);
         sbq.delete();
      end else begin
         chk("count", 32'(count), 32'(mcount));
         chk("count_max", 32'(count <= 3'(DEPTH)), 32'd1);
         chk("a_ready", 32'(a_ready), 32'(mcount < DEPTH));
         chk("b_ready", 32'(b_ready), 32'(mcount < DEPTH && !a_valid));
         chk("we", 32'(we), 32'(mcount != 0));
         if (we) begin
            if (sbq.size() == 0) begin
               vecs++;
               miss++;
               $display("FAIL unexpected_write: got waddr %0d, expected no write", waddr);
            end else begin
               e = sbq.pop_front();
               chk("waddr", 32'(waddr), 32'(e.a));
               chk("wdata", wdata, e.d);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
      a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
      chk_addr1 = 5'd5; chk_addr2 = 5'd3;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_we", 32'(we), 32'd0);
      chk("rst_waddr", 32'(waddr), 32'd0);
      chk("rst_wdata", wdata, 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_busy1", 32'(chk_busy1), 32'd0);
      chk("rst_busy2", 32'(chk_busy2), 32'd0);
      chk("rst_a_ready", 32'(a_ready), 32'd1);
      chk("rst_b_ready", 32'(b_ready), 32'd1);
      // single write to r5
      step();
      a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h1234_5678;
      @(negedge clk);
      chk("single_busy_incoming", 32'(chk_busy1), 32'd0);
      step();
      a_valid = 1'b0;
      @(negedge clk);
      chk("single_we", 32'(we), 32'd1);
      chk("single_waddr", 32'(waddr), 32'd5);
      chk("single_wdata", wdata, 32'h1234_5678);
      chk("single_busy", 32'(chk_busy1), 32'd1);
      step();
      @(negedge clk);
      chk("single_we_after", 32'(we), 32'd0);
      chk("single_count_after", 32'(count), 32'd0);
      chk("single_busy_after", 32'(chk_busy1), 32'd0);
      // priority: A wins, B follows
      step();
      a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hA;
      b_valid = 1'b1; b_addr = 5'd4; b_data = 32'hB;
      @(negedge clk);
      chk("prio_b_ready", 32'(b_ready), 32'd0);
      step();
      a_valid = 1'b0;
      @(negedge clk);
      chk("prio_b_ready_free", 32'(b_ready), 32'd1);
      chk("prio_waddr_first", 32'(waddr), 32'd3);
      chk("prio_busy_r3", 32'(chk_busy2), 32'd1);
      step();
      b_valid = 1'b0;
      @(negedge clk);
      chk("prio_waddr_second", 32'(waddr), 32'd4);
      // r0 write is accepted and dropped
      step();
      b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hFFFF_FFFF; chk_addr1 = 5'd0;
      @(negedge clk);
      chk("zero_b_ready", 32'(b_ready), 32'd1);
      step();
      b_valid = 1'b0;
      @(negedge clk);
      chk("zero_count", 32'(count), 32'd0);
      chk("zero_we", 32'(we), 32'd0);
      chk("zero_busy", 32'(chk_busy1), 32'd0);
      // same-address ordering on r7
      step();
      a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h1; chk_addr1 = 5'd7;
      @(negedge clk);
      step();
      a_data = 32'h2;
      @(negedge clk);
      chk("same_busy_first", 32'(chk_busy1), 32'd1);
      chk("same_wdata_first", wdata, 32'h1);
      step();
      a_valid = 1'b0;
      @(negedge clk);
      chk("same_busy_second", 32'(chk_busy1), 32'd1);
      chk("same_wdata_second", wdata, 32'h2);
      step();
      @(negedge clk);
      chk("same_busy_done", 32'(chk_busy1), 32'd0);
      // both producers every cycle, pointers wrap several times
      for (int i = 0; i < 12; i++) begin
         step();
         a_valid = (i % 3) != 2; a_addr = 5'(i + 1); a_data = 32'(100 + i);
         b_valid = 1'b1; b_addr = 5'(20 + i); b_data = 32'(200 + i);
         @(negedge clk);
      end
      step();
      a_valid = 1'b0; b_valid = 1'b0;
      repeat (2) @(negedge clk);
      // reset mid-flight drops the pending entry and ignores the handshake
      step();
      a_valid = 1'b1; a_addr = 5'd10; a_data = 32'hAA;
      step();
      a_addr = 5'd11; a_data = 32'hBB;
      step();
      rst = 1'b1; a_addr = 5'd12; a_data = 32'hCC;
      @(negedge clk);
      chk("midrst_we", 32'(we), 32'd0);
      step();
      rst = 1'b0; a_valid = 1'b0;
      @(negedge clk);
      chk("midrst_count", 32'(count), 32'd0);
      chk("midrst_we_after", 32'(we), 32'd0);
      repeat (4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end
endmodule
